// File: rtl/rom_arb_pkg.sv
// Shared types for the ROM port arbiter: requester limits, index width helper
// and the {valid, idx} tag carried alongside each ROM read.
package rom_arb_pkg;

    localparam int MAX_REQ = 8;
    localparam int IDX_W   = $clog2(MAX_REQ);

    // Index width for a given requester count; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    typedef logic [IDX_W-1:0] idx_t;

    typedef struct packed {
        logic valid;
        idx_t idx;
    } tag_t;

endpackage

// File: rtl/rom_port_arbiter_if.sv
// Requester and ROM-side signals of the ROM port arbiter, bundled with
// modports for the arbiter (slave) and the surrounding logic (master).
interface rom_port_arbiter_if #(
    parameter int NUM_REQ = 6,
    parameter int ADDR_W  = 18,
    parameter int DATA_W  = 4
);

    // Handshake: req[i] is a level held (with a stable req_addr slice) until
    // gnt[i] pulses for one cycle; req[i] still high the cycle after gnt[i]
    // is a new request, dropping req[i] before gnt[i] withdraws it. Each
    // issued request returns exactly one rsp_valid[i] pulse, in issue order.
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        gnt;
    logic                      rom_en;
    logic [ADDR_W-1:0]         rom_addr;
    logic [DATA_W-1:0]         rom_q;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;

    modport slave (
        input  req, req_addr, rom_q,
        output gnt, rom_en, rom_addr, rsp_valid, rsp_data
    );

    modport master (
        output req, req_addr, rom_q,
        input  gnt, rom_en, rom_addr, rsp_valid, rsp_data
    );

endinterface

// File: rtl/rom_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit at or after ptr,
// wrapping from NUM_REQ-1 back to 0.
module rr_pick #(
    parameter int NUM_REQ = 6,
    parameter int IW      = 3
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic               any,
    output logic [IW-1:0]      idx
);

    logic [IW:0]   cand;
    logic [IW-1:0] cand_idx;

    // Walk offsets from farthest to nearest so the nearest hit is the last write.
    always_comb begin
        any      = 1'b0;
        idx      = '0;
        cand     = '0;
        cand_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (IW + 1)'(k);
            if (cand >= (IW + 1)'(NUM_REQ)) begin
                cand = cand - (IW + 1)'(NUM_REQ);
            end
            cand_idx = cand[IW-1:0];
            if (req[cand_idx]) begin
                any = 1'b1;
                idx = cand_idx;
            end
        end
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// Round-robin arbiter sharing one synchronous ROM read port among NUM_REQ
// requesters. Define ROM_ARB_PRIO0_EN to give requester 0 strict priority.
module rom_port_arbiter
    import rom_arb_pkg::*;
#(
    parameter int  NUM_REQ = 6,
    parameter int  ADDR_W  = 18,
    parameter int  DATA_W  = 4,
    parameter int  ROM_LAT = 2,
    localparam int IW      = idx_w(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset_n,
    rom_port_arbiter_if.slave  bus,
    output logic [IW-1:0]      rr_ptr_dbg
);

    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
        $error("rom_port_arbiter: NUM_REQ must be 2..%0d", MAX_REQ);
    end
    if (ROM_LAT < 1 || ROM_LAT > 4) begin : g_bad_rom_lat
        $error("rom_port_arbiter: ROM_LAT must be 1..4");
    end

    logic [IW-1:0]      rr_ptr;
    logic [IW-1:0]      ptr_next;
    logic [IW-1:0]      pick_idx;
    logic [IW-1:0]      win_idx;
    logic [IW-1:0]      issue_idx;
    logic               pick_any;
    logic               win_any;
    logic [NUM_REQ-1:0] pick_req;
    logic [ADDR_W-1:0]  win_addr;

    logic [NUM_REQ-1:0] gnt_r;
    logic               rom_en_r;
    logic [ADDR_W-1:0]  rom_addr_r;
    logic [NUM_REQ-1:0] rsp_valid_r;
    logic [DATA_W-1:0]  rsp_data_r;

    tag_t tag_pipe [ROM_LAT];
    tag_t tag_out;

    // With priority enabled requester 0 is removed from the rotation and
    // overrides it below, so the pointer only reflects the other requesters.
    always_comb begin
`ifdef ROM_ARB_PRIO0_EN
        pick_req = bus.req & ~NUM_REQ'(1);
`else
        pick_req = bus.req;
`endif
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .req (pick_req),
        .ptr (rr_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_comb begin
        win_any  = pick_any;
        win_idx  = pick_idx;
        ptr_next = rr_ptr;
        if (pick_any) begin
            ptr_next = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + IW'(1);
        end
`ifdef ROM_ARB_PRIO0_EN
        if (bus.req[0]) begin
            win_any  = 1'b1;
            win_idx  = '0;
            ptr_next = rr_ptr;
        end
`endif
        win_addr = bus.req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
    end

    // Issue stage: grant pulse, ROM enable/address and the winner's index.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt_r      <= '0;
            rom_en_r   <= 1'b0;
            rom_addr_r <= '0;
            issue_idx  <= '0;
            rr_ptr     <= '0;
        end else begin
            gnt_r     <= win_any ? (NUM_REQ'(1) << win_idx) : '0;
            rom_en_r  <= win_any;
            issue_idx <= win_idx;
            rr_ptr    <= ptr_next;
            if (win_any) begin
                rom_addr_r <= win_addr;
            end
        end
    end

    // The issue register is the first ROM cycle, so ROM_LAT tag stages land
    // the tag on the same edge the ROM word becomes valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < ROM_LAT; k++) begin
                tag_pipe[k] <= '0;
            end
        end else begin
            tag_pipe[0] <= '{valid: rom_en_r, idx: idx_t'(issue_idx)};
            for (int k = 1; k < ROM_LAT; k++) begin
                tag_pipe[k] <= tag_pipe[k-1];
            end
        end
    end

    assign tag_out = tag_pipe[ROM_LAT-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid_r <= '0;
            rsp_data_r  <= '0;
        end else begin
            rsp_valid_r <= tag_out.valid ? (NUM_REQ'(1) << tag_out.idx) : '0;
            if (tag_out.valid) begin
                rsp_data_r <= bus.rom_q;
            end
        end
    end

    assign bus.gnt       = gnt_r;
    assign bus.rom_en    = rom_en_r;
    assign bus.rom_addr  = rom_addr_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_data  = rsp_data_r;
    assign rr_ptr_dbg    = rr_ptr;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Randomized bench for rom_port_arbiter: a cycle-level reference model of the
// arbitration rules plus a ROM model and an expected-response queue.
module tb_rom_port_arbiter;

    localparam int NUM_REQ = 6;
    localparam int ADDR_W  = 18;
    localparam int DATA_W  = 4;
    localparam int ROM_LAT = 2;
    localparam int IW      = $clog2(NUM_REQ);
    localparam int RSP_W   = 32 + 8 + DATA_W;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [IW-1:0] rr_ptr_dbg;

    rom_port_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    rom_port_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .ROM_LAT (ROM_LAT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus.slave),
        .rr_ptr_dbg (rr_ptr_dbg)
    );

    // ---------------- clock ----------------
    always #20 clk = ~clk;

    // ---------------- ROM model ----------------
    function automatic logic [DATA_W-1:0] rom_fn(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] t;
        t = a ^ (a >> 5) ^ (a >> 11) ^ (a >> 15);
        return t[DATA_W-1:0];
    endfunction

    logic [DATA_W-1:0] rom_pipe [ROM_LAT];
    always @(posedge clk) begin
        rom_pipe[0] <= rom_fn(bus.rom_addr);
        for (int k = 1; k < ROM_LAT; k++) rom_pipe[k] <= rom_pipe[k-1];
    end
    assign bus.rom_q = rom_pipe[ROM_LAT-1];

    // ---------------- scoreboard / model state ----------------
    int                n_checks = 0;
    int                n_fail   = 0;
    int                cyc      = 0;
    int                m_ptr    = 0;
    logic [ADDR_W-1:0] m_addr   = '0;
    logic [DATA_W-1:0] m_rsp    = '0;
    logic [RSP_W-1:0]  exp_q[$];
    logic [ADDR_W-1:0] addr_v [NUM_REQ];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic drive_addrs();
        for (int i = 0; i < NUM_REQ; i++) bus.req_addr[i*ADDR_W +: ADDR_W] = addr_v[i];
    endtask

    // One clock: present r, predict the edge, then compare every output.
    task automatic run_cycle(input logic [NUM_REQ-1:0] r);
        int                 win;
        int                 c;
        logic [NUM_REQ-1:0] e_gnt;
        logic [NUM_REQ-1:0] e_rv;
        logic [DATA_W-1:0]  e_rd;
        logic [RSP_W-1:0]   head;
        bus.req = r;
        drive_addrs();
        win = -1;
`ifdef ROM_ARB_PRIO0_EN
        if (r[0]) win = 0;
`endif
        if (win < 0) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                c = (m_ptr + k) % NUM_REQ;
                if (win < 0 && r[c]) win = c;
            end
            if (win >= 0) m_ptr = (win + 1) % NUM_REQ;
        end
        e_gnt = '0;
        if (win >= 0) begin
            e_gnt  = NUM_REQ'(1) << win;
            m_addr = addr_v[win];
            exp_q.push_back({32'(cyc + ROM_LAT + 2), 8'(win), rom_fn(m_addr)});
        end

        @(posedge clk);
        #1;
        cyc++;

        e_rv = '0;
        e_rd = m_rsp;
        if (exp_q.size() > 0 && exp_q[0][RSP_W-1 -: 32] == 32'(cyc)) begin
            head  = exp_q.pop_front();
            e_rv  = NUM_REQ'(1) << head[DATA_W +: 8];
            e_rd  = head[DATA_W-1:0];
            m_rsp = e_rd;
        end
        check_eq("gnt",       32'(bus.gnt),       32'(e_gnt));
        check_eq("rom_en",    32'(bus.rom_en),    32'(win >= 0));
        check_eq("rom_addr",  32'(bus.rom_addr),  32'(m_addr));
        check_eq("rr_ptr",    32'(rr_ptr_dbg),    32'(m_ptr));
        check_eq("rsp_valid", 32'(bus.rsp_valid), 32'(e_rv));
        check_eq("rsp_data",  32'(bus.rsp_data),  32'(e_rd));

        // A requester that keeps req high after a grant presents a new address.
        for (int i = 0; i < NUM_REQ; i++)
            if (e_gnt[i]) addr_v[i] = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
    endtask

    task automatic do_reset(input int n, input logic [NUM_REQ-1:0] r);
        @(negedge clk);
        reset_n = 1'b0;
        bus.req = r;
        drive_addrs();
        #1;
        check_eq("rst_async_gnt",    32'(bus.gnt),       32'(0));
        check_eq("rst_async_rom_en", 32'(bus.rom_en),    32'(0));
        check_eq("rst_async_rsp",    32'(bus.rsp_valid), 32'(0));
        m_ptr  = 0;
        m_addr = '0;
        m_rsp  = '0;
        exp_q.delete();
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
            check_eq("rst_gnt",       32'(bus.gnt),       32'(0));
            check_eq("rst_rom_en",    32'(bus.rom_en),    32'(0));
            check_eq("rst_rom_addr",  32'(bus.rom_addr),  32'(0));
            check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
            check_eq("rst_rsp_data",  32'(bus.rsp_data),  32'(0));
            check_eq("rst_rr_ptr",    32'(rr_ptr_dbg),    32'(0));
        end
        reset_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [NUM_REQ-1:0] r;
        int                 density;
        int                 ptr_before;

        bus.req = '0;
        for (int i = 0; i < NUM_REQ; i++) addr_v[i] = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
        drive_addrs();

        // Reset held with every requester active, then the first grant.
        do_reset(3, '1);
        run_cycle('1);
        check_eq("first_gnt", 32'(bus.gnt), 32'(1));

        // Continuous full request: rotating grants and returning words.
        repeat (13) run_cycle('1);

        // Single sparse request from requester 3, followed by idle cycles.
        repeat (2) run_cycle('0);
        addr_v[3] = 18'h000A5;
        run_cycle(6'h08);
        check_eq("single_gnt",    32'(bus.gnt),      32'(6'h08));
        check_eq("single_addr",   32'(bus.rom_addr), 32'(18'h000A5));
        check_eq("single_rr_ptr", 32'(rr_ptr_dbg),   32'(4));
        repeat (6) run_cycle('0);

        // Reset with two responses still in the pipeline.
        repeat (2) run_cycle('1);
        do_reset(2, '0);
        repeat (6) run_cycle('0);

`ifdef ROM_ARB_PRIO0_EN
        repeat (3) run_cycle(6'h3E);
        ptr_before = m_ptr;
        repeat (5) begin
            run_cycle('1);
            check_eq("prio0_gnt", 32'(bus.gnt), 32'(1));
        end
        run_cycle(6'h3E);
        check_eq("prio0_resume", 32'(bus.gnt), 32'(NUM_REQ'(1) << ((ptr_before == 0) ? 1 : ptr_before)));
`else
        ptr_before = m_ptr;
        run_cycle('1);
        check_eq("rr_resume", 32'(bus.gnt), 32'(NUM_REQ'(1) << ptr_before));
`endif

        // Randomized traffic at varying request densities.
        for (int blk = 0; blk < 4; blk++) begin
            density = $urandom_range(15, 90);
            if (blk == 2) do_reset(1, '1);
            repeat (100) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    r[i] = ($urandom_range(0, 99) < density);
                    if ($urandom_range(0, 7) == 0)
                        addr_v[i] = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
                end
                run_cycle(r);
            end
        end

        // Drain the pipeline so every outstanding response is compared.
        repeat (ROM_LAT + 3) run_cycle('0);
        check_eq("queue_drained", 32'(exp_q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
